switch_input_port: RTL and testbench
====================================

# switch_input_port

Debounced, memory-mapped input port that brings the board's slide switches into the single-cycle CPU. It is the input-side counterpart of the LED/seven-segment output path: raw iSwitch levels are synchronized, debounced on a slow sample tick, latched into a readable register, and accumulated into a change mask. The CPU's load path reads this mask through a small read/write register interface. An optional interrupt line reports changes.

## Interface
- WIDTH, 8, number of switch inputs (1..32)
- TICK_CYCLES, 1_000_000, iClk cycles per debounce sample tick (20 ms at 50 MHz); minimum 2
- STABLE_SAMPLES, 3, consecutive equal samples required to accept a new level (2..8)

- iClk  in  1  system clock
- iRst  in  1  reset, asynchronous, active-high
- iSwitch  in  WIDTH  raw switch levels, asynchronous to iClk
- iAddr  in  2  register select: 0 VALUE, 1 CHANGED, 2 RAW, 3 CTRL
- iRd  in  1  read strobe, one cycle per access
- iWr  in  1  write strobe, one cycle per access
- iWdata  in  32  write data (only CTRL is writable)
- oRdata  out  32  registered read data
- oIrq  out  1  level interrupt, high while (CHANGED != 0) and CTRL.ie

## Operation
- Synchronizer: two-flop chain per bit. sync = second stage.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. tick is high for one cycle when count == TICK_CYCLES-1.
- On tick, each bit shifts sync into an STABLE_SAMPLES-deep history.
- Debounced bit update: if all history entries equal v after the shift, and v != debounced bit, the debounced bit takes v. Mismatched or partial histories leave the bit unchanged.
- CHANGED mask:
  - A bit is set in the cycle its debounced bit toggles.
  - A read of addr 1 clears the mask.
  - If a set and a clear land in the same cycle, the set wins for the newly toggling bits. All other bits clear.
- Register map:
  - VALUE: debounced bits, zero-extended to 32.
  - CHANGED: mask, zero-extended.
  - RAW: sync, zero-extended.
  - CTRL: bit0 ie, all other bits read 0.
- Writes: a write to addr 3 sets ie = iWdata[0]. Writes to addrs 0–2 are ignored.
- Reads: only addr 1 has a read side effect.
- Simultaneous iRd and iWr: both take effect. A read of CTRL in the same cycle as a write of CTRL returns the old value.

## Timing
- Reset values are all 0: both synchronizer stages, tick counter, histories, debounced value, CHANGED, ie, oRdata, oIrq.
- oRdata is loaded on the edge that samples iRd=1 and is valid the following cycle. It holds its value when iRd=0.
- Input-to-VALUE latency for a clean level change:
  - 2 cycles of synchronization.
  - Then the STABLE_SAMPLES-th tick after the synchronized change.
  - Then 1 cycle for the register update.
  - Worst case: 2 + STABLE_SAMPLES·TICK_CYCLES + 1.
- Glitches are rejected if they last less than one full sample interval and do not coincide with STABLE_SAMPLES consecutive ticks.
- oIrq is registered and rises 1 cycle after the CHANGED mask becomes non-zero with ie=1.
  - It falls 1 cycle after the clearing read, unless the set-wins rule kept some bits set.
- Switches that are high out of reset are accepted as changes after STABLE_SAMPLES ticks and set CHANGED. This is intended.
- Asserting iRst mid-debounce discards all history. No partial state survives.

## Configuration
- SWITCH_IRQ_EN defined:
  - CTRL.ie register and oIrq logic are present, as described above.
- SWITCH_IRQ_EN undefined:
  - No ie flop. oIrq is tied to 0.
  - CTRL reads 0 and writes to addr 3 are ignored.
  - Everything else is unchanged.

## Structure
- Shared package holds:
  - Register address constants: ADDR_VALUE=0, ADDR_CHANGED=1, ADDR_RAW=2, ADDR_CTRL=3.
  - CTRL_IE_BIT=0.
  - Default TICK_CYCLES.
- Sub-module tick_gen (parameter TICK_CYCLES; ports iClk, iRst, oTick) generates the sample strobe.
  - It is shared with other slow peripherals, such as display scanning.
- Top level holds the synchronizer, per-bit history, the debounce compare, the CHANGED mask, and the register mux.

## Test plan
All scenarios use TICK_CYCLES=4 and STABLE_SAMPLES=3.

- Reset with iSwitch=8'h00: all outputs 0. Read addr 0 and read addr 1 each return 0.
- Set iSwitch to 8'h5A and hold:
  - VALUE reads 8'h5A no later than cycle 2+12+1 after the change.
  - CHANGED reads 8'h5A, and a second read of addr 1 returns 0.
- Bounce bit0 with a 3-cycle high pulse, then hold low: VALUE bit0 stays 0 and CHANGED stays 0.
- With SWITCH_IRQ_EN defined, write addr 3 with 1, then flip bit7:
  - oIrq rises 1 cycle after CHANGED=8'h80.
  - The read of addr 1 returns 8'h80, and oIrq falls 1 cycle after that read.
- Schedule the toggle of bit3 in the same cycle as a read of addr 1 that finds CHANGED=8'h01:
  - That read returns 8'h01.
  - The next read returns 8'h08.
- Assert iRst halfway through a debounce of iSwitch=8'hFF, then release: VALUE needs a full 3 ticks again before reading 8'hFF.

Source files
------------

// File: rtl/switch_input_port_pkg.sv
// Shared constants for the switch input port: register map and default tick period.
package switch_input_port_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ADDR_VALUE   = 2'd0;
  localparam reg_addr_t ADDR_CHANGED = 2'd1;
  localparam reg_addr_t ADDR_RAW     = 2'd2;
  localparam reg_addr_t ADDR_CTRL    = 2'd3;

  localparam int unsigned CTRL_IE_BIT = 0;

  // 20 ms sample period at 50 MHz
  localparam int unsigned DEFAULT_TICK_CYCLES = 1_000_000;

endpackage

// File: rtl/switch_input_port_if.sv
// CPU-side register bus plus raw switch levels for the switch input port.
interface switch_input_port_if
  import switch_input_port_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0]  iSwitch;
  reg_addr_t         iAddr;
  logic              iRd;
  logic              iWr;
  logic [DATA_W-1:0] iWdata;
  logic [DATA_W-1:0] oRdata;
  logic              oIrq;

  modport master (
    output iSwitch, iAddr, iRd, iWr, iWdata,
    input  oRdata, oIrq
  );

  modport slave (
    input  iSwitch, iAddr, iRd, iWr, iWdata,
    output oRdata, oIrq
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running slow strobe generator shared by low-rate peripherals.
// oTick is high for one cycle while the counter sits at TICK_CYCLES-1.
module tick_gen
  import switch_input_port_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_CYCLES - 2);

  logic [CNT_W-1:0] count;

  // Wrapping counter; the strobe is registered one count early so it lines up with LAST
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count <= '0;
      oTick <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
      oTick <= (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/switch_input_port.sv
// Debounced memory-mapped slide-switch input port.
// Build option: define SWITCH_IRQ_EN to include the CTRL.ie flop and oIrq logic;
// without it oIrq is tied low and CTRL reads zero.
module switch_input_port
  import switch_input_port_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TICK_CYCLES    = DEFAULT_TICK_CYCLES,
  parameter int unsigned STABLE_SAMPLES = 3
) (
  input  logic          iClk,
  input  logic          iRst,
  switch_input_port_if.slave bus
);

  logic [WIDTH-1:0]                     sync_meta;
  logic [WIDTH-1:0]                     sync;
  logic [WIDTH-1:0][STABLE_SAMPLES-1:0] hist;
  logic [WIDTH-1:0][STABLE_SAMPLES-1:0] hist_n_c;
  logic [WIDTH-1:0]                     deb;
  logic [WIDTH-1:0]                     changed;
  logic [WIDTH-1:0]                     toggle_c;
  logic [DATA_W-1:0]                    rd_mux_c;
  logic [DATA_W-1:0]                    rdata;
  logic                                 rd_changed_c;
  logic                                 tick;
  logic                                 ie;
  logic                                 unused_inputs;

  tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick_gen (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (tick)
  );

  // Two-flop synchronizer for the asynchronous switch levels
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= bus.iSwitch;
      sync      <= sync_meta;
    end
  end

  // Next history per bit and the toggles it implies when a tick lands
  always_comb begin
    hist_n_c = hist;
    toggle_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      hist_n_c[i] = {hist[i][STABLE_SAMPLES-2:0], sync[i]};
      if (tick && (&hist_n_c[i]) && !deb[i]) toggle_c[i] = 1'b1;
      if (tick && !(|hist_n_c[i]) && deb[i]) toggle_c[i] = 1'b1;
    end
  end

  assign rd_changed_c = bus.iRd && (bus.iAddr == ADDR_CHANGED);

  // Sample history, debounced value and change mask; new toggles beat a same-cycle clear
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hist    <= '0;
      deb     <= '0;
      changed <= '0;
    end else begin
      if (tick) hist <= hist_n_c;
      deb     <= deb ^ toggle_c;
      changed <= (rd_changed_c ? '0 : changed) | toggle_c;
    end
  end

`ifdef SWITCH_IRQ_EN
  // Interrupt enable and registered level interrupt
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ie              <= 1'b0;
      bus.oIrq        <= 1'b0;
    end else begin
      if (bus.iWr && (bus.iAddr == ADDR_CTRL)) ie <= bus.iWdata[CTRL_IE_BIT];
      bus.oIrq <= ie && (|changed);
    end
  end
`else
  assign ie       = 1'b0;
  assign bus.oIrq = 1'b0;
`endif

  // Only the ie bit of the write path is meaningful
  assign unused_inputs = ^{bus.iWdata, bus.iWr};

  // Register read mux; CTRL returns the pre-write ie value
  always_comb begin
    rd_mux_c = '0;
    case (bus.iAddr)
      ADDR_VALUE:   rd_mux_c = DATA_W'(deb);
      ADDR_CHANGED: rd_mux_c = DATA_W'(changed);
      ADDR_RAW:     rd_mux_c = DATA_W'(sync);
      default:      rd_mux_c[CTRL_IE_BIT] = ie;
    endcase
  end

  // Read data register, held between reads
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) rdata <= '0;
    else if (bus.iRd) rdata <= rd_mux_c;
  end

  assign bus.oRdata = rdata;

endmodule

// File: tb/tb_switch_input_port.sv
// Scoreboard bench for switch_input_port (TICK_CYCLES=4, STABLE_SAMPLES=3).
module tb_switch_input_port;
  import switch_input_port_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned TICK   = 4;
  localparam int unsigned STABLE = 3;
`ifdef SWITCH_IRQ_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   edge_n   = 0;
  logic rd_d;
  logic [31:0] exp_q[$];
  string       name_q[$];

  switch_input_port_if #(.WIDTH(WIDTH)) bus();

  switch_input_port #(
    .WIDTH          (WIDTH),
    .TICK_CYCLES    (TICK),
    .STABLE_SAMPLES (STABLE)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Edges since reset release; tick edges are the multiples of TICK
  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) rd_d <= 1'b0;
    else     rd_d <= bus.iRd;
  end

  // Monitor: compare read data the cycle after each sampled read
  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %08h expected no read", bus.oRdata);
      end else begin
        check(name_q.pop_front(), bus.oRdata, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; the read is sampled on the next posedge
  task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string nm);
    bus.iAddr = a;
    bus.iRd   = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    bus.iRd = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus.iAddr  = a;
    bus.iWdata = d;
    bus.iWr    = 1'b1;
    @(negedge clk);
    bus.iWr = 1'b0;
  endtask

  task automatic do_rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e, input string nm);
    bus.iWdata = d;
    bus.iWr    = 1'b1;
    do_read(a, e, nm);
    bus.iWr = 1'b0;
  endtask

  // Wait for the negedge right after a tick edge
  task automatic align_tick();
    do @(negedge clk); while ((edge_n % TICK) != 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at;
    bus.iSwitch = '0;
    bus.iAddr   = '0;
    bus.iRd     = 1'b0;
    bus.iWr     = 1'b0;
    bus.iWdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdata", bus.oRdata, 32'h0);
    check("reset_irq", 32'(bus.oIrq), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_read(ADDR_VALUE,   32'h00, "reset_value");
    do_read(ADDR_CHANGED, 32'h00, "reset_changed");
    do_read(ADDR_RAW,     32'h00, "reset_raw");
    do_read(ADDR_CTRL,    32'h00, "reset_ctrl");

    // Clean change to 5A accepted within 2+12+1 cycles
    bus.iSwitch = 8'h5A;
    repeat (14) @(negedge clk);
    do_read(ADDR_VALUE,   32'h5A, "value_5a");
    do_read(ADDR_CHANGED, 32'h5A, "changed_5a");
    do_read(ADDR_CHANGED, 32'h00, "changed_cleared");
    do_read(ADDR_RAW,     32'h5A, "raw_5a");
    @(negedge clk);
    check("rdata_hold", bus.oRdata, 32'h5A);

    // 3-cycle glitch on bit0 is rejected
    bus.iSwitch = 8'h5B;
    repeat (3) @(negedge clk);
    bus.iSwitch = 8'h5A;
    repeat (20) @(negedge clk);
    do_read(ADDR_VALUE,   32'h5A, "glitch_value");
    do_read(ADDR_CHANGED, 32'h00, "glitch_changed");
    do_write(ADDR_CHANGED, 32'hFF);
    do_write(ADDR_VALUE, 32'hFFFF_FFFF);
    do_read(ADDR_CHANGED, 32'h00, "ro_changed");
    do_read(ADDR_VALUE,   32'h5A, "ro_value");

    // Interrupt on bit7 change
    do_write(ADDR_CTRL, 32'h1);
    do_read(ADDR_CTRL, 32'(IE), "ctrl_ie_set");
    align_tick();
    bus.iSwitch = 8'hDA;
    rise_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.oIrq && rise_at == 0) rise_at = k;
    end
    check("irq_rise_cycle", 32'(rise_at), IE ? 32'd13 : 32'd0);
    do_read(ADDR_CHANGED, 32'h80, "changed_80");
    check("irq_after_clear_read", 32'(bus.oIrq), 32'(IE));
    @(negedge clk);
    check("irq_fall", 32'(bus.oIrq), 32'h0);
    do_rdwr(ADDR_CTRL, 32'h0, 32'(IE), "ctrl_rdwr_old");
    do_read(ADDR_CTRL, 32'h0, "ctrl_ie_clr");

    // Bit3 toggles on the same edge as a clearing read of CHANGED=01
    align_tick();
    bus.iSwitch = 8'hDB;
    repeat (4) @(negedge clk);
    bus.iSwitch = 8'hD3;
    repeat (11) @(negedge clk);
    do_read(ADDR_CHANGED, 32'h01, "setwin_first");
    do_read(ADDR_CHANGED, 32'h08, "setwin_second");

    // Reset mid-debounce discards history
    bus.iSwitch = 8'hFF;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_rdata", bus.oRdata, 32'h0);
    check("midrst_irq", 32'(bus.oIrq), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (11) @(negedge clk);
    do_read(ADDR_VALUE,   32'h00, "postrst_value_early");
    do_read(ADDR_VALUE,   32'hFF, "postrst_value_ff");
    do_read(ADDR_CHANGED, 32'hFF, "postrst_changed_ff");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL pending_reads: got %0d expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
